// File: rtl/pinmux_bank_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pinmux_bank_pkg
// Description : Shared encodings for the pinmux IO bank (port-stop safe
//               values and edge-interrupt modes).
// Revision    : 1.0 - initial release
// ============================================================================
package pinmux_bank_pkg;

    localparam logic [1:0] SAFE_HIZ  = 2'b00;
    localparam logic [1:0] SAFE_DRV0 = 2'b01;
    localparam logic [1:0] SAFE_DRV1 = 2'b10;
    localparam logic [1:0] SAFE_HOLD = 2'b11;

    localparam logic [1:0] IRQ_OFF   = 2'b00;
    localparam logic [1:0] IRQ_RISE  = 2'b01;
    localparam logic [1:0] IRQ_FALL  = 2'b10;
    localparam logic [1:0] IRQ_BOTH  = 2'b11;

endpackage
`default_nettype wire

// File: rtl/pinmux_pin_filter.sv
`default_nettype none
// ============================================================================
// Module      : pinmux_pin_filter
// Description : Per-pin input conditioning: 2-flop synchroniser, debounce
//               counter and edge-detect interrupt pending flag.
// Revision    : 1.0 - initial release
// ============================================================================
module pinmux_pin_filter
    import pinmux_bank_pkg::*;
#(
    parameter int DEB_WIDTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_raw,
    input  logic [DEB_WIDTH-1:0] i_deb_thresh,
    input  logic [1:0]           i_irq_mode,
    input  logic                 i_irq_clr,
    output logic                 o_state,
    output logic                 o_pending
);

    logic                 r_sync1;
    logic                 r_sync2;
    logic [DEB_WIDTH-1:0] r_cnt;
    logic                 r_st;
    logic                 r_st_d;
    logic                 r_pending;

    logic [DEB_WIDTH-1:0] w_limit_m1;
    logic                 w_rise;
    logic                 w_fall;
    logic                 w_set;

    // A zero threshold behaves as one; ">=" lets a lowered threshold commit at once.
    assign w_limit_m1 = (i_deb_thresh == '0) ? '0 : i_deb_thresh - 1'b1;

    assign w_rise = r_st & ~r_st_d;
    assign w_fall = ~r_st & r_st_d;
    assign w_set  = (w_rise & ((i_irq_mode == IRQ_RISE) || (i_irq_mode == IRQ_BOTH)))
                  | (w_fall & ((i_irq_mode == IRQ_FALL) || (i_irq_mode == IRQ_BOTH)));

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_cnt     <= '0;
            r_st      <= 1'b0;
            r_st_d    <= 1'b0;
            r_pending <= 1'b0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            r_st_d  <= r_st;
            if (r_sync2 == r_st) begin
                r_cnt <= '0;
            end else if (r_cnt >= w_limit_m1) begin
                r_st  <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            // Set has priority over a coincident clear.
            r_pending <= w_set | (r_pending & ~i_irq_clr);
        end
    end

    assign o_state   = r_st;
    assign o_pending = r_pending;

endmodule
`default_nettype wire

// File: rtl/pinmux_io_bank.sv
`default_nettype none
// ============================================================================
// Module      : pinmux_io_bank
// Description : Multi-pin GPIO pinmux bank: output select, open-drain,
//               port-stop override, registered pad drive and input routing.
// Revision    : 1.0 - initial release
// ============================================================================
module pinmux_io_bank
    import pinmux_bank_pkg::*;
#(
    parameter int NUM_PINS        = 8,
    parameter int NUM_PERIPHERALS = 4,
    parameter int SEL_WIDTH       = 5,
    parameter int DEB_WIDTH       = 4
) (
    input  logic                          i_clk,
    input  logic                          i_rst_n,
    input  logic [NUM_PINS*SEL_WIDTH-1:0] i_outfunc_sel,
    input  logic [NUM_PINS*SEL_WIDTH-1:0] i_infunc_sel,
    input  logic [NUM_PINS-1:0]           i_infunc_en,
    input  logic [NUM_PINS-1:0]           i_od,
    input  logic [NUM_PINS-1:0]           i_ie,
    input  logic [NUM_PINS-1:0]           i_gpio_outen,
    input  logic [NUM_PINS-1:0]           i_portstop,
    input  logic [2*NUM_PINS-1:0]         i_portstop_safeval,
    input  logic [NUM_PINS*DEB_WIDTH-1:0] i_deb_thresh,
    input  logic [2*NUM_PINS-1:0]         i_irq_mode,
    input  logic [NUM_PINS-1:0]           i_irq_clr,
    input  logic [NUM_PERIPHERALS-1:0]    i_peripheral_out,
    input  logic [NUM_PERIPHERALS-1:0]    i_peripheral_oe,
    output logic [NUM_PERIPHERALS-1:0]    o_peripheral_in,
    input  logic [NUM_PINS-1:0]           i_pad_in,
    output logic [NUM_PINS-1:0]           o_pad_out,
    output logic [NUM_PINS-1:0]           o_pad_oe,
    output logic [NUM_PINS-1:0]           o_gpio_in,
    output logic [NUM_PINS-1:0]           o_irq_pending,
    output logic                          o_irq
);

    logic [NUM_PERIPHERALS-1:0] w_periph_in;

    generate
        for (genvar n = 0; n < NUM_PINS; n++) begin : g_pin
            logic [SEL_WIDTH-1:0] w_sel;
            logic                 w_d;
            logic                 w_e;
            logic                 w_d_od;
            logic                 w_e_gated;
            logic                 r_out;
            logic                 r_oe;
            logic                 r_hold_out;
            logic                 r_hold_oe;

            assign w_sel = i_outfunc_sel[n*SEL_WIDTH +: SEL_WIDTH];

            // Out-of-range selects fall through to d=0, e=0.
            always_comb begin
                w_d = 1'b0;
                w_e = 1'b0;
                for (int p = 0; p < NUM_PERIPHERALS; p++) begin
                    if (w_sel == SEL_WIDTH'(p)) begin
                        w_d = i_peripheral_out[p];
                        w_e = i_peripheral_oe[p];
                    end
                end
            end

            assign w_d_od    = i_od[n] ? 1'b0 : w_d;
            assign w_e_gated = (i_od[n] ? ~w_d : w_e) & i_gpio_outen[n];

            // The hold shadow tracks the pad registers only while port-stop is
            // low, so it keeps the pre-stop values even if safeval changes later.
            always_ff @(posedge i_clk) begin
                if (!i_rst_n) begin
                    r_out      <= 1'b0;
                    r_oe       <= 1'b0;
                    r_hold_out <= 1'b0;
                    r_hold_oe  <= 1'b0;
                end else if (i_portstop[n]) begin
                    case (i_portstop_safeval[2*n +: 2])
                        SAFE_HIZ:  begin r_out <= 1'b0;       r_oe <= 1'b0;      end
                        SAFE_DRV0: begin r_out <= 1'b0;       r_oe <= 1'b1;      end
                        SAFE_DRV1: begin r_out <= 1'b1;       r_oe <= 1'b1;      end
                        default:   begin r_out <= r_hold_out; r_oe <= r_hold_oe; end
                    endcase
                end else begin
                    r_out      <= w_d_od;
                    r_oe       <= w_e_gated;
                    r_hold_out <= w_d_od;
                    r_hold_oe  <= w_e_gated;
                end
            end

            assign o_pad_out[n] = r_out;
            assign o_pad_oe[n]  = r_oe;

            pinmux_pin_filter #(
                .DEB_WIDTH (DEB_WIDTH)
            ) u_filter (
                .i_clk        (i_clk),
                .i_rst_n      (i_rst_n),
                .i_raw        (i_pad_in[n] & i_ie[n]),
                .i_deb_thresh (i_deb_thresh[n*DEB_WIDTH +: DEB_WIDTH]),
                .i_irq_mode   (i_irq_mode[2*n +: 2]),
                .i_irq_clr    (i_irq_clr[n]),
                .o_state      (o_gpio_in[n]),
                .o_pending    (o_irq_pending[n])
            );
        end
    endgenerate

    always_comb begin
        w_periph_in = '0;
        for (int p = 0; p < NUM_PERIPHERALS; p++) begin
            for (int n = 0; n < NUM_PINS; n++) begin
                if (i_infunc_en[n] && (i_infunc_sel[n*SEL_WIDTH +: SEL_WIDTH] == SEL_WIDTH'(p))) begin
                    w_periph_in[p] = w_periph_in[p] | o_gpio_in[n];
                end
            end
        end
    end

    assign o_peripheral_in = w_periph_in;
    assign o_irq           = |o_irq_pending;

endmodule
`default_nettype wire

// File: tb/tb_pinmux_io_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_pinmux_io_bank
// Description : Directed self-checking bench for pinmux_io_bank.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pinmux_io_bank;

    localparam int NUM_PINS        = 8;
    localparam int NUM_PERIPHERALS = 4;
    localparam int SEL_WIDTH       = 5;
    localparam int DEB_WIDTH       = 4;

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic [NUM_PINS*SEL_WIDTH-1:0] outfunc_sel;
    logic [NUM_PINS*SEL_WIDTH-1:0] infunc_sel;
    logic [NUM_PINS-1:0]           infunc_en;
    logic [NUM_PINS-1:0]           od;
    logic [NUM_PINS-1:0]           ie;
    logic [NUM_PINS-1:0]           gpio_outen;
    logic [NUM_PINS-1:0]           portstop;
    logic [2*NUM_PINS-1:0]         safeval;
    logic [NUM_PINS*DEB_WIDTH-1:0] deb_thresh;
    logic [2*NUM_PINS-1:0]         irq_mode;
    logic [NUM_PINS-1:0]           irq_clr;
    logic [NUM_PERIPHERALS-1:0]    periph_out;
    logic [NUM_PERIPHERALS-1:0]    periph_oe;
    logic [NUM_PERIPHERALS-1:0]    periph_in;
    logic [NUM_PINS-1:0]           pad_in;
    logic [NUM_PINS-1:0]           pad_out;
    logic [NUM_PINS-1:0]           pad_oe;
    logic [NUM_PINS-1:0]           gpio_in;
    logic [NUM_PINS-1:0]           irq_pending;
    logic                          irq;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    pinmux_io_bank #(
        .NUM_PINS        (NUM_PINS),
        .NUM_PERIPHERALS (NUM_PERIPHERALS),
        .SEL_WIDTH       (SEL_WIDTH),
        .DEB_WIDTH       (DEB_WIDTH)
    ) dut (
        .i_clk              (clk),
        .i_rst_n            (rst_n),
        .i_outfunc_sel      (outfunc_sel),
        .i_infunc_sel       (infunc_sel),
        .i_infunc_en        (infunc_en),
        .i_od               (od),
        .i_ie               (ie),
        .i_gpio_outen       (gpio_outen),
        .i_portstop         (portstop),
        .i_portstop_safeval (safeval),
        .i_deb_thresh       (deb_thresh),
        .i_irq_mode         (irq_mode),
        .i_irq_clr          (irq_clr),
        .i_peripheral_out   (periph_out),
        .i_peripheral_oe    (periph_oe),
        .o_peripheral_in    (periph_in),
        .i_pad_in           (pad_in),
        .o_pad_out          (pad_out),
        .o_pad_oe           (pad_oe),
        .o_gpio_in          (gpio_in),
        .o_irq_pending      (irq_pending),
        .o_irq              (irq)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        outfunc_sel = '0;
        infunc_sel  = '0;
        infunc_en   = '0;
        od          = '0;
        ie          = '0;
        gpio_outen  = '0;
        portstop    = '0;
        safeval     = '0;
        deb_thresh  = '0;
        irq_mode    = '0;
        irq_clr     = '0;
        periph_out  = '0;
        periph_oe   = '0;
        pad_in      = '0;

        tick(2);
        check("rst_pad_out", 32'(pad_out), 32'h0);
        check("rst_pad_oe", 32'(pad_oe), 32'h0);
        check("rst_gpio_in", 32'(gpio_in), 32'h0);
        check("rst_irq", 32'(irq), 32'h0);
        check("rst_periph_in", 32'(periph_in), 32'h0);
        rst_n = 1'b1;

        // Output select
        periph_out       = 4'b0100;
        periph_oe        = 4'b0100;
        outfunc_sel[4:0] = 5'd2;
        gpio_outen[0]    = 1'b1;
        tick();
        check("sel2_out", 32'(pad_out[0]), 32'h1);
        check("sel2_oe", 32'(pad_oe[0]), 32'h1);
        outfunc_sel[4:0] = 5'd7;
        tick();
        check("sel7_out", 32'(pad_out[0]), 32'h0);
        check("sel7_oe", 32'(pad_oe[0]), 32'h0);

        // Open-drain
        outfunc_sel[4:0] = 5'd2;
        od[0]            = 1'b1;
        tick();
        check("od_d1_oe", 32'(pad_oe[0]), 32'h0);
        check("od_d1_out", 32'(pad_out[0]), 32'h0);
        periph_out[2] = 1'b0;
        tick();
        check("od_d0_oe", 32'(pad_oe[0]), 32'h1);
        check("od_d0_out", 32'(pad_out[0]), 32'h0);

        // Port-stop safe values
        od[0]         = 1'b0;
        periph_out[2] = 1'b1;
        tick();
        check("norm_out", 32'({pad_out[0], pad_oe[0]}), 32'h3);
        periph_out[2] = 1'b0;
        portstop[0]   = 1'b1;
        safeval[1:0]  = 2'b10;
        tick();
        check("ps_drv1", 32'({pad_out[0], pad_oe[0]}), 32'h3);
        safeval[1:0] = 2'b01;
        tick();
        check("ps_drv0", 32'({pad_out[0], pad_oe[0]}), 32'h1);
        safeval[1:0] = 2'b00;
        tick();
        check("ps_hiz", 32'({pad_out[0], pad_oe[0]}), 32'h0);

        // Port-stop hold
        portstop[0]   = 1'b0;
        periph_out[2] = 1'b1;
        tick();
        check("pre_hold", 32'({pad_out[0], pad_oe[0]}), 32'h3);
        portstop[0]   = 1'b1;
        safeval[1:0]  = 2'b11;
        periph_out[2] = 1'b0;
        tick();
        check("hold_a", 32'({pad_out[0], pad_oe[0]}), 32'h3);
        periph_oe[2] = 1'b0;
        tick();
        check("hold_b", 32'({pad_out[0], pad_oe[0]}), 32'h3);
        safeval[1:0] = 2'b10;
        tick();
        safeval[1:0] = 2'b11;
        periph_out[2] = 1'b1;
        tick();
        check("hold_after_drv1", 32'({pad_out[0], pad_oe[0]}), 32'h3);
        portstop[0]   = 1'b0;
        periph_out[2] = 1'b0;
        tick();
        check("ps_release", 32'({pad_out[0], pad_oe[0]}), 32'h0);

        // Debounce on pin 2, threshold 4
        deb_thresh[11:8] = 4'd4;
        ie[2]            = 1'b1;
        pad_in[2]        = 1'b1;
        tick(3);
        pad_in[2] = 1'b0;
        tick(8);
        check("glitch_rejected", 32'(gpio_in[2]), 32'h0);

        irq_mode[5:4] = 2'b11;
        tick();
        check("mode_no_set", 32'(irq_pending[2]), 32'h0);
        pad_in[2] = 1'b1;
        tick(5);
        check("deb_rise_early", 32'(gpio_in[2]), 32'h0);
        tick();
        check("deb_rise", 32'(gpio_in[2]), 32'h1);
        check("pend_lag", 32'(irq_pending[2]), 32'h0);
        tick();
        check("pend_rise", 32'(irq_pending[2]), 32'h1);
        check("irq_rise", 32'(irq), 32'h1);
        tick(3);
        irq_clr[2] = 1'b1;
        tick();
        irq_clr[2] = 1'b0;
        check("pend_clr", 32'(irq_pending[2]), 32'h0);

        // Fall edge with coincident clear
        pad_in[2] = 1'b0;
        tick(6);
        check("deb_fall", 32'(gpio_in[2]), 32'h0);
        check("pend_pre_fall", 32'(irq_pending[2]), 32'h0);
        irq_clr[2] = 1'b1;
        tick();
        irq_clr[2] = 1'b0;
        check("set_wins", 32'(irq_pending[2]), 32'h1);
        irq_clr[2] = 1'b1;
        tick();
        irq_clr[2] = 1'b0;
        check("pend_clr2", 32'(irq_pending[2]), 32'h0);
        check("irq_clr2", 32'(irq), 32'h0);

        // Input routing: pins 1 and 3 to peripheral 0, zero threshold
        infunc_en[1]  = 1'b1;
        infunc_en[3]  = 1'b1;
        ie[1]         = 1'b1;
        ie[3]         = 1'b1;
        irq_mode[7:6] = 2'b11;
        pad_in[3]     = 1'b1;
        tick(2);
        check("thr0_early", 32'(gpio_in[3]), 32'h0);
        tick();
        check("thr0_rise", 32'(gpio_in[3]), 32'h1);
        tick();
        check("route_or", 32'(periph_in), 32'h1);
        infunc_en[3] = 1'b0;
        #1;
        check("route_dis", 32'(periph_in), 32'h0);
        check("pend3", 32'(irq_pending[3]), 32'h1);

        // Reset in the middle of a debounce count
        outfunc_sel[4:0] = 5'd2;
        periph_out[2]    = 1'b1;
        periph_oe[2]     = 1'b1;
        pad_in[2]        = 1'b1;
        tick(4);
        check("pre_rst_pad", 32'({pad_out[0], pad_oe[0]}), 32'h3);
        check("pre_rst_gpio2", 32'(gpio_in[2]), 32'h0);
        rst_n = 1'b0;
        tick();
        check("mid_rst_pad_out", 32'(pad_out), 32'h0);
        check("mid_rst_pad_oe", 32'(pad_oe), 32'h0);
        check("mid_rst_gpio", 32'(gpio_in), 32'h0);
        check("mid_rst_pend", 32'(irq_pending), 32'h0);
        check("mid_rst_irq", 32'(irq), 32'h0);
        rst_n     = 1'b1;
        pad_in[3] = 1'b0;
        tick(5);
        check("post_rst_early", 32'(gpio_in[2]), 32'h0);
        tick();
        check("post_rst_rise", 32'(gpio_in[2]), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
